// File: rtl/fc3_buffer_drain.sv
// Bank-swap controller and scaled read-out for the fc3 double-buffered accumulator.
// Build option: define FC3_DRAIN_SAT_EN to saturate read-out values instead of wrapping them.
module fc3_buffer_drain #(
  parameter int ODIM    = 10,
  parameter int OWID    = 23,
  parameter int ACC_CYC = 1024,
  parameter int SHIFT   = 10,
  parameter int OUTW    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iStart,
  input  logic                      iStop,
  input  logic                      iValid,
  output logic                      oInReady,
  output logic                      oAccSel,
  output logic                      oClear,
  output logic                      oHold,
  input  logic [OWID*ODIM-1:0]      iData,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [OUTW-1:0]           oData,
  output logic [$clog2(ODIM)-1:0]   oIdx,
  output logic                      oLast,
  output logic                      oBusy,
  output logic [2:0]                oDbgState
);

  localparam int IW = $clog2(ODIM);
  localparam int CW = $clog2(ACC_CYC);
  localparam logic [CW-1:0] LAST_BEAT = CW'(ACC_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(ODIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_ACC, S_WAIT} ctrl_state_t;
  typedef enum logic {D_IDLE, D_SEND} drain_state_t;

  ctrl_state_t   state_q, state_d;
  drain_state_t  dstate_q, dstate_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          stop_q, stop_d;
  logic          sel_q, sel_d;
  logic          drain_start;

  // Handshakes: upstream beat = iValid & oInReady; downstream transfer = oValid & iReady.
  // oValid/oData/oIdx hold steady until the transfer happens.

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    sel_d       = sel_q;
    drain_start = 1'b0;
    oInReady    = 1'b0;
    oHold       = 1'b1;
    oClear      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) state_d = S_CLR;
      end
      S_CLR: begin
        oClear  = 1'b1;
        oHold   = 1'b0;
        beat_d  = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        oInReady = 1'b1;
        oHold    = ~iValid;
        if (iValid) begin
          beat_d = beat_q + CW'(1);
          if (beat_q == LAST_BEAT) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Swap only with the drain idle so the output bank never changes mid-drain.
        if (dstate_q == D_IDLE) begin
          sel_d       = ~sel_q;
          drain_start = 1'b1;
          state_d     = (stop_q || iStop) ? S_IDLE : S_CLR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    stop_d = ((state_d == S_IDLE) && (state_q != S_IDLE)) ? 1'b0 : (stop_q | iStop);
  end

  always_comb begin
    dstate_d = dstate_q;
    idx_d    = idx_q;
    case (dstate_q)
      D_IDLE: begin
        if (drain_start) begin
          dstate_d = D_SEND;
          idx_d    = '0;
        end
      end
      D_SEND: begin
        if (iReady) begin
          if (idx_q == LAST_IDX) begin
            dstate_d = D_IDLE;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: dstate_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dstate_q <= D_IDLE;
      beat_q   <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dstate_q <= dstate_d;
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      sel_q    <= sel_d;
    end
  end

  logic signed [OWID-1:0] elem;
  logic signed [OWID-1:0] shifted;
  logic                   ovf;

  always_comb begin
    elem    = iData[int'(idx_q)*OWID +: OWID];
    shifted = elem >>> SHIFT;
    // Value fits in OUTW bits only if all bits above the OUTW sign bit match it.
    ovf     = (shifted[OWID-1:OUTW-1] != {(OWID-OUTW+1){shifted[OWID-1]}});
`ifdef FC3_DRAIN_SAT_EN
    if (ovf) oData = shifted[OWID-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
    else     oData = shifted[OUTW-1:0];
`else
    oData = shifted[OUTW-1:0];
`endif
  end

  assign oAccSel   = sel_q;
  assign oValid    = (dstate_q == D_SEND);
  assign oIdx      = idx_q;
  assign oLast     = oValid && (idx_q == LAST_IDX);
  assign oBusy     = (state_q != S_IDLE) || (dstate_q == D_SEND);
  assign oDbgState = {dstate_q, state_q};

endmodule

// File: tb/tb_fc3_buffer_drain.sv
// Directed bench for fc3_buffer_drain: cycle table for two frames, then backpressure,
// saturation/wrap, stop and mid-drain reset sequences.
module tb_fc3_buffer_drain;
  localparam int ODIM = 4, OWID = 23, ACC_CYC = 4, SHIFT = 2, OUTW = 8;

`ifdef FC3_DRAIN_SAT_EN
  localparam logic [7:0] EXP_BIG = 8'd127;
`else
  localparam logic [7:0] EXP_BIG = 8'd244;
`endif

  logic clk, rst_n, iStart, iStop, iValid, iReady;
  logic oInReady, oAccSel, oClear, oHold, oValid, oLast, oBusy;
  logic [OWID*ODIM-1:0] iData;
  logic [OUTW-1:0] oData;
  logic [1:0] oIdx;
  logic [2:0] oDbgState;

  int errors = 0;
  int checks = 0;

  fc3_buffer_drain #(.ODIM(ODIM), .OWID(OWID), .ACC_CYC(ACC_CYC), .SHIFT(SHIFT), .OUTW(OUTW)) dut (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .iStop(iStop), .iValid(iValid),
    .oInReady(oInReady), .oAccSel(oAccSel), .oClear(oClear), .oHold(oHold),
    .iData(iData), .oValid(oValid), .iReady(iReady), .oData(oData), .oIdx(oIdx),
    .oLast(oLast), .oBusy(oBusy), .oDbgState(oDbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int e0, input int e1, input int e2, input int e3);
    iData = {OWID'(e3), OWID'(e2), OWID'(e1), OWID'(e0)};
  endtask

  task automatic cyc(input logic st, input logic sp, input logic v, input logic r);
    @(posedge clk);
    #1;
    iStart = st; iStop = sp; iValid = v; iReady = r;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] in;   // {start, stop, valid, ready}
    logic [4:0] o;    // {inReady, accSel, clear, hold, oValid}
    logic [1:0] idx;
    logic [7:0] d;
    logic [1:0] lb;   // {last, busy}
  } vec_t;

  function automatic vec_t mk(input logic [3:0] in, input logic [4:0] o, input logic [1:0] idx,
                              input logic [7:0] d, input logic [1:0] lb);
    vec_t v;
    v.in = in; v.o = o; v.idx = idx; v.d = d; v.lb = lb;
    return v;
  endfunction

  vec_t tbl[20];
  logic [7:0] exp_d[4];
  logic [3:0] pat;

  initial begin
    int exp_i, xf;
    logic hit;
    exp_d = '{8'h0A, 8'hFD, 8'h01, 8'h00};
    pat = 4'b1001;
    // frame 1, then frame 2 with a stop pulse and its drain back to idle
    tbl[0]  = mk(4'b0000, 5'b00010, 2'd0, 8'h0A, 2'b00);
    tbl[1]  = mk(4'b1000, 5'b00010, 2'd0, 8'h0A, 2'b00);
    tbl[2]  = mk(4'b0000, 5'b00100, 2'd0, 8'h0A, 2'b01);
    tbl[3]  = mk(4'b0010, 5'b10000, 2'd0, 8'h0A, 2'b01);
    tbl[4]  = mk(4'b0000, 5'b10010, 2'd0, 8'h0A, 2'b01);
    tbl[5]  = mk(4'b0010, 5'b10000, 2'd0, 8'h0A, 2'b01);
    tbl[6]  = mk(4'b0010, 5'b10000, 2'd0, 8'h0A, 2'b01);
    tbl[7]  = mk(4'b0010, 5'b10000, 2'd0, 8'h0A, 2'b01);
    tbl[8]  = mk(4'b0001, 5'b00010, 2'd0, 8'h0A, 2'b01);
    tbl[9]  = mk(4'b0001, 5'b01101, 2'd0, 8'h0A, 2'b01);
    tbl[10] = mk(4'b0011, 5'b11001, 2'd1, 8'hFD, 2'b01);
    tbl[11] = mk(4'b0111, 5'b11001, 2'd2, 8'h01, 2'b01);
    tbl[12] = mk(4'b0011, 5'b11001, 2'd3, 8'h00, 2'b11);
    tbl[13] = mk(4'b0010, 5'b11000, 2'd0, 8'h0A, 2'b01);
    tbl[14] = mk(4'b0001, 5'b01010, 2'd0, 8'h0A, 2'b01);
    tbl[15] = mk(4'b0001, 5'b00011, 2'd0, 8'h0A, 2'b01);
    tbl[16] = mk(4'b0001, 5'b00011, 2'd1, 8'hFD, 2'b01);
    tbl[17] = mk(4'b0001, 5'b00011, 2'd2, 8'h01, 2'b01);
    tbl[18] = mk(4'b0001, 5'b00011, 2'd3, 8'h00, 2'b11);
    tbl[19] = mk(4'b0000, 5'b00010, 2'd0, 8'h0A, 2'b00);

    rst_n = 1'b0; iStart = 1'b0; iStop = 1'b0; iValid = 1'b0; iReady = 1'b0;
    load(40, -12, 7, 3);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("r%0d_inready", i), oInReady, tbl[i].o[4]);
      chk($sformatf("r%0d_accsel", i),  oAccSel,  tbl[i].o[3]);
      chk($sformatf("r%0d_clear", i),   oClear,   tbl[i].o[2]);
      chk($sformatf("r%0d_hold", i),    oHold,    tbl[i].o[1]);
      chk($sformatf("r%0d_valid", i),   oValid,   tbl[i].o[0]);
      chk($sformatf("r%0d_idx", i),     oIdx,     tbl[i].idx);
      chk($sformatf("r%0d_data", i),    oData,    tbl[i].d);
      chk($sformatf("r%0d_last", i),    oLast,    tbl[i].lb[1]);
      chk($sformatf("r%0d_busy", i),    oBusy,    tbl[i].lb[0]);
    end

    // backpressure 1,0,0,1 during the drain; the next frame end must stall in WAIT
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("a_idle_busy", oBusy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a_clr", oClear, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("a_acc%0d_inready", i), oInReady, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("a_wait_inready", oInReady, 1'b0);
    chk("a_wait_sel", oAccSel, 1'b0);
    exp_i = 0;
    xf = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 1'b1, pat[k % 4]);
      chk($sformatf("a_k%0d_valid", k), oValid, 1'b1);
      chk($sformatf("a_k%0d_idx", k), oIdx, exp_i);
      chk($sformatf("a_k%0d_data", k), oData, exp_d[exp_i]);
      if (k == 0) begin
        chk("a_k0_sel", oAccSel, 1'b1);
        chk("a_k0_clr", oClear, 1'b1);
      end
      if (k >= 5) begin
        chk($sformatf("a_k%0d_stall_inready", k), oInReady, 1'b0);
        chk($sformatf("a_k%0d_stall_hold", k), oHold, 1'b1);
      end
      if (oValid && iReady) xf++;
      if (iReady) exp_i++;
    end
    chk("a_transfers", xf, 4);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("a_k8_valid", oValid, 1'b0);
    chk("a_k8_inready", oInReady, 1'b0);
    chk("a_k8_hold", oHold, 1'b1);
    chk("a_k8_sel", oAccSel, 1'b1);

    // swap back, large element 0 for narrowing, stop pulse for this frame
    load(2000, -12, 7, 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("b_sel", oAccSel, 1'b0);
    chk("b_clr", oClear, 1'b1);
    chk("b_valid", oValid, 1'b1);
    chk("b_idx", oIdx, 2'd0);
    chk("b_narrow", oData, EXP_BIG);
    load(40, -12, 7, 3);
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      if (!oBusy) begin
        hit = 1'b1;
        break;
      end
    end
    chk("b_stop_idle", hit, 1'b1);
    chk("b_stop_sel", oAccSel, 1'b1);

    // reset in the middle of a drain with bank 1 selected
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      if (oValid && oAccSel && oIdx == 2'd1) begin
        hit = 1'b1;
        break;
      end
    end
    chk("c_mid_drain", hit, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("c_rst_inready", oInReady, 1'b0);
    chk("c_rst_sel", oAccSel, 1'b0);
    chk("c_rst_clear", oClear, 1'b0);
    chk("c_rst_hold", oHold, 1'b1);
    chk("c_rst_valid", oValid, 1'b0);
    chk("c_rst_idx", oIdx, 2'd0);
    chk("c_rst_last", oLast, 1'b0);
    chk("c_rst_busy", oBusy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc3_buffer_drain.md
# fc3_buffer_drain

Controller and read-out for the fc3 double-buffered accumulator. It drives the accumulator's bank-select, clear and hold controls and gates upstream valid data. At each frame boundary it swaps banks and streams the completed bank out one element per handshake, scaled and narrowed to OUTW bits. It sits between the fc3 accumulator bank and the downstream result consumer.

## Interface
- ODIM, 10, number of accumulator elements per bank
- OWID, 23, accumulator element width (two's complement)
- ACC_CYC, 1024, accepted input cycles per frame (≥2)
- SHIFT, 10, arithmetic right shift applied on read-out (< OWID)
- OUTW, 8, output element width (two's complement, ≤ OWID − SHIFT)

- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- iStart  in  1  begin frames; sampled only in IDLE
- iStop  in  1  sticky stop request; honoured at the next frame end
- iValid  in  1  upstream accumulator input valid
- oInReady  out  1  upstream may present data; a beat counts when iValid & oInReady
- oAccSel  out  1  accumulator bank select (0: bank0 accumulates, bank1 is output)
- oClear  out  1  zero the accumulating bank
- oHold  out  1  freeze the accumulating bank
- iData  in  OWID×ODIM  output-bank contents from the accumulator
- oValid  out  1  read-out element valid
- iReady  in  1  downstream accepts the element
- oData  out  OUTW  scaled element
- oIdx  out  $clog2(ODIM)  element index of oData
- oLast  out  1  oValid on element ODIM−1
- oBusy  out  1  controller is not in IDLE, or drain is active

## Operation
- Controller FSM: IDLE, CLR, ACC, WAIT.
  - IDLE: oHold=1, oInReady=0, oClear=0. iStart → CLR.
  - CLR: one cycle. oClear=1, oHold=0, oInReady=0. Always → ACC. Beat counter = 0.
  - ACC: oInReady=1, oHold=~iValid. The beat counter increments on each accepted beat. Accepted beat with counter == ACC_CYC−1 → WAIT.
  - WAIT: oInReady=0, oHold=1.
    - If the drain is idle: toggle oAccSel, start the drain, then go to IDLE if a stop is pending, else CLR.
    - If the drain is busy: remain in WAIT (upstream stalled).
- Stop: iStop sets a sticky flag in any state. The flag clears when the controller enters IDLE. A frame in progress always completes and drains.
- Drain FSM: D_IDLE, D_SEND.
  - Start: idx=0, go to D_SEND.
  - D_SEND: oValid=1. On oValid & iReady: idx+1, or → D_IDLE after idx ODIM−1.
- oData = narrow(iData[idx] >>> SHIFT), arithmetic shift. oData is combinational from iData and idx and is stable while unaccepted.
- iData is the non-accumulating bank. It is stable for the whole drain because the controller swaps banks only with the drain idle.

## Timing
- Reset values: oAccSel=0, oClear=0, oHold=1, oInReady=0, oValid=0, oIdx=0, oLast=0, oBusy=0. Beat counter, stop flag and both FSMs are cleared.
- Reset asserted mid-frame or mid-drain takes effect at the next edge. All in-flight data is discarded.
- WAIT to swap: oAccSel toggles on the exit edge from WAIT.
- First oValid appears in the cycle immediately after that edge, concurrent with CLR.
- Throughput: one element per cycle with iReady held high. A drain lasts ODIM cycles.
- Frame period with no backpressure: ACC_CYC accepted beats + 1 WAIT + 1 CLR cycle.
- iStart outside IDLE is ignored. iStart and iStop together in IDLE: one frame runs, then the controller returns to IDLE.

## Configuration
- FC3_DRAIN_SAT_EN
  - Defined: narrow() saturates to [−2^(OUTW−1), 2^(OUTW−1)−1].
  - Undefined: narrow() keeps the low OUTW bits (wrap-around).

## Test plan
Bench parameters: ODIM=4, ACC_CYC=4, SHIFT=2, OUTW=8.
- Reset, then iStart with 4 valid beats:
  - CLR is 1 cycle with oClear=1.
  - oInReady stays high for exactly 4 accepted beats, then drops.
  - oAccSel goes 0→1 one cycle after WAIT.
- Output-bank iData = {40, −12, 7, 3}, iReady=1: oData = 10, −3, 1, 0 on consecutive cycles; oIdx 0..3; oLast only on idx 3.
- iReady toggled 1,0,0,1…: oData/oIdx hold while unaccepted; exactly 4 transfers occur.
- iReady low at the next frame end: controller sits in WAIT with oInReady=0 and oHold=1. After the drain completes, the swap occurs with oAccSel toggling back to 0.
- iData[0] = 2000: with FC3_DRAIN_SAT_EN, oData = 127; without it, oData = 500 mod 256 = 244 (0xF4).
- iStop asserted mid-frame 2: frame 2 completes and drains, then IDLE with oBusy=0. rst_n low during a drain gives all outputs their reset values next cycle.
